// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Two-phase instruction fetch stage. Holds the program memory,
//             the PC and the instruction register.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int ADDR_W = 7
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic              LD_EN,
    input  logic [ADDR_W-1:0] LD_ADR,
    input  logic [15:0]       LD_DATA,
    input  logic              STALL,
    input  logic              HALT_REQ,
    input  logic [1:0]        S,
    input  logic [15:0]       JA,
    output logic [15:0]       INST,
    output logic [15:0]       PC,
    output logic              INST_VALID,
    output logic              BUSY,
    output logic              FAULT
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [15:0]  r_mem [c_DEPTH];
    logic [15:0]  r_pc;
    logic [15:0]  r_inst;
    logic         r_fault;
    logic         r_inst_valid;
    logic         r_busy;

    logic         w_stopped;
    logic         w_mem_we;
    logic         w_pc_oob;
    logic [15:0]  w_br_off;
    logic [15:0]  w_pc_exec;

    assign w_stopped = (r_state == ST_IDLE) || (r_state == ST_HALT);
    assign w_mem_we  = w_stopped && LD_EN && !RESET;
    assign w_pc_oob  = (r_pc >> ADDR_W) != 16'd0;
    assign w_br_off  = {{10{r_inst[8]}}, r_inst[8:6], r_inst[2:0]};

    // Next PC for a non-stalled EXEC; relative offsets are from this PC.
    always_comb begin
        w_pc_exec = r_pc + 16'd1;
        case (S)
            2'b00:   w_pc_exec = r_pc + 16'd1;
            2'b01:   w_pc_exec = JA;
            default: w_pc_exec = r_pc + w_br_off;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                if (START) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_nxt = w_pc_oob ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                if (!STALL) begin
                    w_state_nxt = HALT_REQ ? ST_HALT : ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Program memory is deliberately outside the reset domain.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[LD_ADR] <= LD_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pc         <= 16'h0000;
            r_inst       <= 16'h0000;
            r_fault      <= 1'b0;
            r_inst_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_inst_valid <= (w_state_nxt == ST_EXEC);
            r_busy       <= (w_state_nxt == ST_FETCH) || (w_state_nxt == ST_EXEC);
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (START) begin
                        r_pc    <= 16'h0000;
                        r_fault <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (w_pc_oob) begin
                        r_fault <= 1'b1;
                        r_inst  <= 16'h0000;
                    end else begin
                        r_inst  <= r_mem[r_pc[ADDR_W-1:0]];
                    end
                end
                ST_EXEC: begin
                    if (!STALL) begin
                        r_pc <= w_pc_exec;
                    end
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    assign INST       = r_inst;
    assign PC         = r_pc;
    assign INST_VALID = r_inst_valid;
    assign BUSY       = r_busy;
    assign FAULT      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed vector bench for fetch_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, start, ld_en, stall, hreq;
    logic [6:0]  ld_adr;
    logic [15:0] ld_data, ja;
    logic [1:0]  s;
    logic [15:0] inst, pc;
    logic        inst_valid, busy, fault;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(7)) dut (
        .CLK(clk), .RESET(rst), .START(start), .LD_EN(ld_en),
        .LD_ADR(ld_adr), .LD_DATA(ld_data), .STALL(stall), .HALT_REQ(hreq),
        .S(s), .JA(ja), .INST(inst), .PC(pc), .INST_VALID(inst_valid),
        .BUSY(busy), .FAULT(fault)
    );

    typedef struct {
        logic        rst, start, ld_en;
        logic [6:0]  ld_adr;
        logic [15:0] ld_data;
        logic        stall, hreq;
        logic [1:0]  s;
        logic [15:0] ja;
        logic [15:0] e_pc, e_inst;
        logic        e_v, e_b, e_f;
    } vec_t;

    function automatic vec_t mk(
        input logic r, input logic st, input logic le, input logic [6:0] la,
        input logic [15:0] ld, input logic sl, input logic hr, input logic [1:0] sv,
        input logic [15:0] j, input logic [15:0] epc, input logic [15:0] einst,
        input logic ev, input logic eb, input logic ef);
        vec_t v;
        v.rst = r; v.start = st; v.ld_en = le; v.ld_adr = la; v.ld_data = ld;
        v.stall = sl; v.hreq = hr; v.s = sv; v.ja = j;
        v.e_pc = epc; v.e_inst = einst; v.e_v = ev; v.e_b = eb; v.e_f = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst = v.rst; start = v.start; ld_en = v.ld_en; ld_adr = v.ld_adr;
        ld_data = v.ld_data; stall = v.stall; hreq = v.hreq; s = v.s; ja = v.ja;
        @(posedge clk);
        #1;
        chk("pc",         idx, pc,                 v.e_pc);
        chk("inst",       idx, inst,               v.e_inst);
        chk("inst_valid", idx, {15'd0, inst_valid}, {15'd0, v.e_v});
        chk("busy",       idx, {15'd0, busy},       {15'd0, v.e_b});
        chk("fault",      idx, {15'd0, fault},      {15'd0, v.e_f});
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_adr = '0; ld_data = '0;
        stall = 1'b0; hreq = 1'b0; s = 2'b00; ja = '0;

        //                rst st le adr    data      sl hr s      ja         pc        inst      v  b  f
        tbl.push_back(mk(1, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 7'h00, 16'h0BAD, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 7'h01, 16'h2222, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 7'h02, 16'h3333, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 7'h03, 16'h3A3A, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 7'h04, 16'h01C6, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 7'h05, 16'h0003, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 7'h08, 16'h8888, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0));
        // START together with a load to address 0
        tbl.push_back(mk(0, 1, 1, 7'h00, 16'h1111, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h1111, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0001, 16'h1111, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0001, 16'h2222, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0002, 16'h2222, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0002, 16'h3333, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0003, 16'h3333, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0003, 16'h3A3A, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 1, 2'b00, 16'h0000, 16'h0004, 16'h3A3A, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 1, 1, 2'b01, 16'h0055, 16'h0004, 16'h3A3A, 0, 0, 0));
        // restart, then jump / relative branches
        tbl.push_back(mk(0, 1, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h3A3A, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h1111, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0001, 16'h1111, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0001, 16'h2222, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b01, 16'h0004, 16'h0004, 16'h2222, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0004, 16'h01C6, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b10, 16'h0000, 16'h0002, 16'h01C6, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0002, 16'h3333, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b01, 16'h0005, 16'h0005, 16'h3333, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0005, 16'h0003, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b11, 16'h0000, 16'h0008, 16'h0003, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0008, 16'h8888, 1, 1, 0));
        // out-of-range jump -> fault
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b01, 16'h0080, 16'h0080, 16'h8888, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0080, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 7'h09, 16'h9999, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h1111, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b01, 16'h0009, 16'h0009, 16'h1111, 0, 1, 0));
        // START/LD_EN/STALL/HALT_REQ in FETCH must all be ignored
        tbl.push_back(mk(0, 1, 1, 7'h09, 16'hDEAD, 1, 1, 2'b00, 16'h0000, 16'h0009, 16'h9999, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b01, 16'h0009, 16'h0009, 16'h9999, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0009, 16'h9999, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b01, 16'h0000, 16'h0000, 16'h9999, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h1111, 1, 1, 0));
        // 0x1111 encodes offset -31: PC wraps to 0xFFE1, then faults
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b10, 16'h0000, 16'hFFE1, 16'h1111, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'hFFE1, 16'h0000, 0, 0, 1));

        foreach (tbl[i]) apply(tbl[i], i);

        // Stall sequence: loads attempted during EXEC must not land
        apply(mk(0, 1, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0), 100);
        apply(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h1111, 1, 1, 0), 101);
        apply(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b01, 16'h0003, 16'h0003, 16'h1111, 0, 1, 0), 102);
        apply(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0003, 16'h3A3A, 1, 1, 0), 103);
        for (int k = 0; k < 3; k++)
            apply(mk(0, 1, 1, 7'h03, 16'hBEEF, 1, 1, 2'b01, 16'h0007, 16'h0003, 16'h3A3A, 1, 1, 0), 104 + k);
        apply(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0004, 16'h3A3A, 0, 1, 0), 107);
        apply(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0004, 16'h01C6, 1, 1, 0), 108);
        apply(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b01, 16'h0003, 16'h0003, 16'h01C6, 0, 1, 0), 109);
        apply(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0003, 16'h3A3A, 1, 1, 0), 110);

        // Reset mid-EXEC, then memory must survive for the restart
        apply(mk(1, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b01, 16'h0040, 16'h0000, 16'h0000, 0, 0, 0), 200);
        apply(mk(0, 1, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0), 201);
        apply(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0000, 16'h1111, 1, 1, 0), 202);
        apply(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0001, 16'h1111, 0, 1, 0), 203);
        apply(mk(0, 0, 0, 7'h00, 16'h0000, 0, 0, 2'b00, 16'h0000, 16'h0001, 16'h2222, 1, 1, 0), 204);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
